// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit: forwarding select
// encoding, execute-stage shadow record and the forwarding priority function.
package hazard_pkg;

  localparam int HZ_ADDR_WIDTH = 5;
  // Shadow indices are held at this width; ADDR_WIDTH must not exceed it.
  localparam int REG_IDX_W = 8;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     regwrite;
    logic     isload;
  } shadow_e_t;

  // Memory stage wins over writeback; x0 is never a forwarding source.
  function automatic fwd_sel_t fwd_select(
    input reg_idx_t src,
    input reg_idx_t m_rd,
    input logic     m_we,
    input reg_idx_t w_rd,
    input logic     w_we
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (m_we && (m_rd != '0) && (m_rd == src))
      sel = FWD_MEM;
    else if (w_we && (w_rd != '0) && (w_rd == src))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall/flush performance-debug events.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc_i && (count_reg != {WIDTH{1'b1}}))
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign count_o = count_reg;

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, control flush and operand forwarding for the D/E pipeline
// register, driven from locally tracked E/M/W shadow state.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH  = HZ_ADDR_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  Rs1D_i,
  input  logic [ADDR_WIDTH-1:0]  Rs2D_i,
  input  logic [ADDR_WIDTH-1:0]  RdD_i,
  input  logic                   RegWriteD_i,
  input  logic                   ResultSrcD_i,
  input  logic                   PCSrcE_i,
  output logic                   StallF_o,
  output logic                   StallD_o,
  output logic                   FlushD_o,
  output logic                   FlushE_o,
  output logic [1:0]             ForwardAE_o,
  output logic [1:0]             ForwardBE_o,
  output logic [COUNT_WIDTH-1:0] StallCount_o,
  output logic [COUNT_WIDTH-1:0] FlushCount_o
);

  reg_idx_t  rs1_d;
  reg_idx_t  rs2_d;
  reg_idx_t  rd_d;

  shadow_e_t e_reg, e_next;
  reg_idx_t  m_rd_reg, w_rd_reg;
  logic      m_we_reg, w_we_reg;

  logic      lw_stall;
  logic      flush_e;
  fwd_sel_t  fwd_a, fwd_b;

  assign rs1_d = reg_idx_t'(Rs1D_i);
  assign rs2_d = reg_idx_t'(Rs2D_i);
  assign rd_d  = reg_idx_t'(RdD_i);

  // A resolving branch discards the dependent instruction, so it must not stall.
  assign lw_stall = e_reg.isload && (e_reg.rd != '0)
                    && ((e_reg.rd == rs1_d) || (e_reg.rd == rs2_d))
                    && !PCSrcE_i;
  assign flush_e  = lw_stall || PCSrcE_i;

  always_comb begin
    e_next = '0;
    if (!flush_e) begin
      e_next.rs1      = rs1_d;
      e_next.rs2      = rs2_d;
      e_next.rd       = rd_d;
      e_next.regwrite = RegWriteD_i;
      e_next.isload   = ResultSrcD_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_reg    <= '0;
      m_rd_reg <= '0;
      m_we_reg <= 1'b0;
      w_rd_reg <= '0;
      w_we_reg <= 1'b0;
    end else begin
      e_reg    <= e_next;
      m_rd_reg <= e_reg.rd;
      m_we_reg <= e_reg.regwrite;
      w_rd_reg <= m_rd_reg;
      w_we_reg <= m_we_reg;
    end
  end

  assign fwd_a = fwd_select(e_reg.rs1, m_rd_reg, m_we_reg, w_rd_reg, w_we_reg);
  assign fwd_b = fwd_select(e_reg.rs2, m_rd_reg, m_we_reg, w_rd_reg, w_we_reg);

  assign StallF_o    = lw_stall;
  assign StallD_o    = lw_stall;
  assign FlushD_o    = PCSrcE_i;
  assign FlushE_o    = flush_e;
  assign ForwardAE_o = fwd_a;
  assign ForwardBE_o = fwd_b;

  // Index 0 counts load-use stalls, index 1 counts control flushes.
  logic [1:0]             cnt_inc;
  logic [COUNT_WIDTH-1:0] cnt_val [2];

  assign cnt_inc = {PCSrcE_i, lw_stall};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(
        .WIDTH (COUNT_WIDTH)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (cnt_inc[gi]),
        .count_o (cnt_val[gi])
      );
    end
  endgenerate

  assign StallCount_o = cnt_val[0];
  assign FlushCount_o = cnt_val[1];

endmodule
